// File: rtl/fpu_req_arbiter_if.sv
// Shared FPU types and the requester/core handshake bundle
// used by the round-robin FPU request arbiter.
package definitions;

    typedef logic [31:0] float_t;

    typedef enum logic [4:0] {
        FPU_ADD  = 5'd0,
        FPU_SUB  = 5'd1,
        FPU_MUL  = 5'd2,
        FPU_DIV  = 5'd3,
        FPU_SQRT = 5'd4,
        FPU_MIN  = 5'd5,
        FPU_MAX  = 5'd6,
        FPU_CMP  = 5'd7
    } fpu_op_t;

    typedef struct packed {
        fpu_op_t op;
        float_t  a;
        float_t  b;
    } fpu_instruction_t;

    typedef struct packed {
        logic inf;
        logic snan;
        logic qnan;
        logic ine;
        logic overflow;
        logic underflow;
        logic zero;
        logic div_by_zero;
    } fpu_flags_t;

    localparam float_t     CANON_QNAN = 32'h7FC0_0000;
    localparam fpu_flags_t QNAN_FLAGS = 8'h20;

endpackage

interface fpu_req_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import definitions::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    fpu_instruction_t [NUM_REQ-1:0] req_instr;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [NUM_REQ-1:0]             rsp_ready;
    float_t                         rsp_result;
    fpu_flags_t                     rsp_flags;
    logic                           rsp_err;
    logic                           fpu_start;
    fpu_instruction_t               fpu_instr;
    logic                           fpu_done;
    float_t                         fpu_out;
    fpu_flags_t                     fpu_flags;
    logic                           busy;

    modport master (
        output req_valid, req_instr, rsp_ready,
        output fpu_done, fpu_out, fpu_flags,
        input  req_ready, rsp_valid, rsp_result,
        input  rsp_flags, rsp_err, fpu_start,
        input  fpu_instr, busy
    );

    modport slave (
        input  req_valid, req_instr, rsp_ready,
        input  fpu_done, fpu_out, fpu_flags,
        output req_ready, rsp_valid, rsp_result,
        output rsp_flags, rsp_err, fpu_start,
        output fpu_instr, busy
    );

endinterface

// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing one non-pipelined FPU core
// among NUM_REQ requesters, with a watchdog on the core.
module fpu_req_arbiter
    import definitions::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    fpu_req_arbiter_if.slave  bus
);

    localparam int PW  = $clog2(NUM_REQ);
    localparam int PW1 = PW + 1;
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    grant_q, grant_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    fpu_instruction_t instr_q, instr_d;
    float_t           result_q, result_d;
    fpu_flags_t       flags_q, flags_d;
    logic             err_q, err_d;

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [PW-1:0]        off;
    logic [PW:0]          sum;
    logic [PW-1:0]        gnt;
    logic                 gnt_vld;

    // Rotate so bit 0 is the requester just after ptr.
    assign dbl = {bus.req_valid, bus.req_valid};
    assign rot = NUM_REQ'(dbl >> ({1'b0, ptr_q} + PW1'(1)));

    always_comb begin
        gnt_vld = 1'b0;
        off     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_vld = 1'b1;
                off     = PW'(k);
            end
        end
        sum = {1'b0, ptr_q} + PW1'(1) + {1'b0, off};
        if (sum >= PW1'(NUM_REQ)) begin
            gnt = PW'(sum - PW1'(NUM_REQ));
        end else begin
            gnt = PW'(sum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= PW'(NUM_REQ - 1);
            grant_q  <= '0;
            cnt_q    <= '0;
            instr_q  <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    instr_d = bus.req_instr[gnt];
                    grant_d = gnt;
                    ptr_d   = gnt;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done on the watchdog's last cycle still wins.
                if (bus.fpu_done) begin
                    result_d = bus.fpu_out;
                    flags_d  = bus.fpu_flags;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    result_d = CANON_QNAN;
                    flags_d  = QNAN_FLAGS;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready[grant_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state_q == S_IDLE && gnt_vld) begin
            bus.req_ready = NUM_REQ'(1) << gnt;
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (state_q == S_RESP) begin
            bus.rsp_valid = NUM_REQ'(1) << grant_q;
        end
    end

    assign bus.fpu_start  = (state_q == S_START);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.fpu_instr  = instr_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_flags  = flags_q;
    assign bus.rsp_err    = err_q;

endmodule

// File: doc/fpu_req_arbiter.md
# fpu_req_arbiter

Round-robin arbiter and sequencer that shares one non-pipelined FPU core among `NUM_REQ` requesters. Each requester hands over a complete `fpu_instruction_t` with a valid/ready handshake. The block drives the core with a one-cycle start pulse and waits for its done pulse, with a watchdog on that wait. It returns the `float_t` result and exception flags to the granted requester over a valid/ready response channel. It sits between the requester-side ports and the FPU core, and uses the `definitions` package types.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 64: maximum WAIT cycles before abort, at least 2.
- `clk`  in  1  system clock; every register updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_instr`  in  NUM_REQ x 69  packed array of `fpu_instruction_t`.
- `rsp_valid`  out  NUM_REQ  response valid; one-hot or zero.
- `rsp_ready`  in  NUM_REQ  response accept.
- `rsp_result`  out  32  `float_t` result.
- `rsp_flags`  out  8  {inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero}.
- `rsp_err`  out  1  response produced by a timeout abort.
- `fpu_start`  out  1  one-cycle pulse to the core.
- `fpu_instr`  out  69  instruction to the core.
- `fpu_done`  in  1  core completion pulse.
- `fpu_out`  in  32  core result, valid while `fpu_done` is high.
- `fpu_flags`  in  8  core flags, same ordering as `rsp_flags`, valid while `fpu_done` is high.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **States:** IDLE, START, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is high, grant the first requester found searching from `ptr+1` upward, wrapping modulo NUM_REQ.
  - `req_ready[g]` is driven combinationally high in that same cycle.
  - On that edge: latch `req_instr[g]` into `fpu_instr`, `grant_id <= g`, `ptr <= g`, then go to START.
- **START**
  - `fpu_start` = 1 for exactly this cycle.
  - Clear the watchdog counter, then go to WAIT.
- **WAIT**
  - `fpu_done` is sampled only in this state; done in START, RESP or IDLE is ignored.
  - On done: latch `fpu_out` and `fpu_flags`, set `rsp_err` = 0, go to RESP.
  - Otherwise the counter increments each cycle. When it reaches TIMEOUT-1 without done, abort: load `rsp_result` = 32'h7FC00000, `rsp_flags` = only qnan set, `rsp_err` = 1, go to RESP.
- **RESP**
  - `rsp_valid[grant_id]` = 1; result, flags and `rsp_err` are held stable.
  - When `rsp_ready[grant_id]` is high, go to IDLE. `rsp_ready` of other requesters is ignored.
- **Stability:** `fpu_instr` holds its value from the grant until the next grant.
- **Priority:** `req_ready` is zero outside IDLE; no new request is accepted before the prior response completes.
- **Reset:** `ptr` resets to NUM_REQ-1, so requester 0 has first priority after reset.
- **Simultaneous events:** `fpu_done` arriving on the timeout cycle counts as a normal done, with `rsp_err` = 0.

## Timing
- **Reset values:** state IDLE; `req_ready`, `rsp_valid`, `fpu_start`, `rsp_err` and `busy` = 0; `fpu_instr`, `rsp_result` and `rsp_flags` = 0; `ptr` = NUM_REQ-1; counter = 0.
- **Latency** (request accepted at edge T):
  - `fpu_start` is high in cycle T+1.
  - The earliest done is accepted in cycle T+2.
  - `rsp_valid` rises in the cycle after done is accepted.
  - The response handshake completes at the first cycle with ready high; IDLE follows.
- **Throughput:** minimum 4 cycles per operation.
- **Timeout:** the abort response appears TIMEOUT+2 cycles after acceptance.
- **Reset mid-operation:** asserting `rst_n` low clears all state immediately (asynchronous). The in-flight operation is dropped with no response; a later `fpu_done` is ignored because the block is in IDLE.

## Test plan
- **Single request:** requester 2 only, valid with ADD 1.0+2.0 (3F800000, 40000000); core returns 40400000 three cycles after start -> `req_ready[2]` pulses once, `fpu_start` pulses once, `rsp_valid[2]` high with `rsp_result` 40400000, `rsp_err` = 0.
- **Fairness:** all four requesters valid continuously, immediate `rsp_ready` -> grant order 0,1,2,3,0,1; no requester is granted twice before the others.
- **Response backpressure:** hold `rsp_ready` low for 10 cycles in RESP -> `rsp_valid`, `rsp_result` and `rsp_flags` stay constant, `req_ready` stays 0, `busy` stays 1, no further `fpu_start`.
- **Timeout:** TIMEOUT=8, core never asserts done -> response 10 cycles after acceptance with 7FC00000, qnan=1, `rsp_err`=1. A late `fpu_done` in RESP changes nothing.
- **Done on the last WAIT cycle** -> normal response, `rsp_err`=0.
- **Reset mid-WAIT:** pull `rst_n` low for 1 cycle -> all outputs 0 immediately. A following `fpu_done` produces no response; the next grant goes to requester 0.
